// File: rtl/cnu_minsum_serial_pkg.sv
// Shared constants and types for the serial min-sum check-node unit and
// the check-to-variable message generator that consumes its results.
package cnu_minsum_serial_pkg;

    localparam int W    = 10;          // message width, two's complement
    localparam int DC   = 6;           // check-node degree (messages per row)
    localparam int IDXW = 3;           // edge index width, ceil(log2(DC))
    localparam int MW   = W - 1;       // magnitude width

    // Largest representable magnitude; -2^(W-1) is clamped to this.
    localparam logic [MW-1:0] MAG_MAX = {MW{1'b1}};

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/cnu_minsum_serial_sm_convert_sat.sv
// Two's-complement to sign/magnitude conversion. The single value with no
// positive counterpart, -2^(W-1), is clamped to the largest magnitude so the
// magnitude always fits in W-1 bits. Purely combinational.
module sm_convert_sat #(
    parameter int W = 10
) (
    input  logic signed [W-1:0] i_msg,
    output logic                o_sign,
    output logic        [W-2:0] o_mag
);

    logic signed [W-1:0] w_neg;
    logic                w_is_min;

    assign w_neg    = -i_msg;
    assign w_is_min = (i_msg == {1'b1, {(W-1){1'b0}}});
    assign o_sign   = i_msg[W-1];

    // Select magnitude: negate negatives, clamp the most-negative code.
    always_comb begin
        o_mag = i_msg[W-2:0];
        if (w_is_min) begin
            o_mag = {(W-1){1'b1}};
        end else if (i_msg[W-1]) begin
            o_mag = w_neg[W-2:0];
        end
    end

endmodule

// File: rtl/cnu_minsum_serial.sv
// Serial min-sum check-node unit. Accepts one variable-to-check message per
// transfer over a row of DC messages, tracks the two smallest magnitudes, the
// index of the smallest and the per-edge signs, then holds the row result
// under a valid/ready handshake until the downstream generator takes it.
module cnu_minsum_serial
    import cnu_minsum_serial_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_msg,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [MW-1:0]   min1,
    output logic [MW-1:0]   min2,
    output logic [IDXW-1:0] min1_idx,
    output logic [DC-1:0]   sign_vec,
    output logic            sign_all
);

    state_t          r_state;
    logic [IDXW-1:0] r_cnt;

    // Running row state; only meaningful between transfers of the same row.
    logic [MW-1:0]   r_r1;
    logic [MW-1:0]   r_r2;
    logic [IDXW-1:0] r_ridx;
    logic [DC-1:0]   r_sv;

    // Held row result.
    logic [MW-1:0]   r_min1;
    logic [MW-1:0]   r_min2;
    logic [IDXW-1:0] r_min1_idx;
    logic [DC-1:0]   r_sign_vec;
    logic            r_sign_all;

    logic            w_xfer;
    logic            w_last;
    logic            w_first;
    logic            w_sign;
    logic [MW-1:0]   w_mag;
    logic [MW-1:0]   w_r1_eff;
    logic [MW-1:0]   w_r2_eff;
    logic [IDXW-1:0] w_ridx_eff;
    logic [MW-1:0]   w_n1;
    logic [MW-1:0]   w_n2;
    logic [IDXW-1:0] w_nidx;
    logic [DC-1:0]   w_sv_next;

    sm_convert_sat #(
        .W (W)
    ) u_conv (
        .i_msg  (in_msg),
        .o_sign (w_sign),
        .o_mag  (w_mag)
    );

    assign in_ready  = (r_state == ACCUM);
    assign out_valid = (r_state == HOLD);
    assign w_xfer    = in_valid && (r_state == ACCUM);
    assign w_first   = (r_cnt == '0);
    assign w_last    = (r_cnt == IDXW'(DC - 1));

    // A new row starts from "infinite" mins so nothing from the previous row leaks in.
    assign w_r1_eff   = w_first ? MAG_MAX : r_r1;
    assign w_r2_eff   = w_first ? MAG_MAX : r_r2;
    assign w_ridx_eff = w_first ? '0 : r_ridx;

    // Running two-min update; a tie with min1 only refreshes min2, so the first occurrence keeps the index.
    always_comb begin
        w_n1   = w_r1_eff;
        w_n2   = w_r2_eff;
        w_nidx = w_ridx_eff;
        if (w_mag < w_r1_eff) begin
            w_n1   = w_mag;
            w_n2   = w_r1_eff;
            w_nidx = r_cnt;
        end else if (w_mag < w_r2_eff) begin
            w_n2   = w_mag;
        end
    end

    // Insert this message's sign at its edge position.
    always_comb begin
        w_sv_next = r_sv;
        for (int i = 0; i < DC; i++) begin
            if (r_cnt == IDXW'(i)) begin
                w_sv_next[i] = w_sign;
            end
        end
    end

    // Row sequencing: count transfers in ACCUM, park in HOLD until the result is taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ACCUM;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_state <= HOLD;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state <= ACCUM;
                    end
                end
                default: begin
                    r_state <= ACCUM;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Running mins and signs advance on every accepted message.
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_r1   <= w_n1;
            r_r2   <= w_n2;
            r_ridx <= w_nidx;
            r_sv   <= w_sv_next;
        end
    end

    // Capture the completed row into the held result on the last transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_min1     <= '0;
            r_min2     <= '0;
            r_min1_idx <= '0;
            r_sign_vec <= '0;
            r_sign_all <= 1'b0;
        end else if (w_xfer && w_last) begin
            r_min1     <= w_n1;
            r_min2     <= w_n2;
            r_min1_idx <= w_nidx;
            r_sign_vec <= w_sv_next;
            r_sign_all <= ^w_sv_next;
        end
    end

    assign min1     = r_min1;
    assign min2     = r_min2;
    assign min1_idx = r_min1_idx;
    assign sign_vec = r_sign_vec;
    assign sign_all = r_sign_all;

endmodule

// File: tb/tb_cnu_minsum_serial.sv
// Randomized and directed bench for the serial min-sum check-node unit.
module tb_cnu_minsum_serial;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_msg;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] min1;
    logic [8:0] min2;
    logic [2:0] min1_idx;
    logic [5:0] sign_vec;
    logic       sign_all;

    int n_chk;
    int n_err;
    int cyc;
    int xfer_cyc;

    cnu_minsum_serial dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_msg    (in_msg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .min1      (min1),
        .min2      (min2),
        .min1_idx  (min1_idx),
        .sign_vec  (sign_vec),
        .sign_all  (sign_all)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: magnitudes by plain abs with clamp, min1 = first smallest,
    // min2 = smallest among the remaining edges, parity from count of negatives.
    task automatic model(input int m[6], output int e1, output int e2,
                         output int eidx, output int esv, output int esa);
        int mag[6];
        int negs;
        negs = 0;
        esv  = 0;
        for (int i = 0; i < 6; i++) begin
            mag[i] = (m[i] < 0) ? -m[i] : m[i];
            if (mag[i] > 511) mag[i] = 511;
            if (m[i] < 0) begin
                esv  = esv | (1 << i);
                negs = negs + 1;
            end
        end
        eidx = 0;
        for (int i = 1; i < 6; i++) if (mag[i] < mag[eidx]) eidx = i;
        e1 = mag[eidx];
        e2 = 1 << 20;
        for (int i = 0; i < 6; i++) if (i != eidx && mag[i] < e2) e2 = mag[i];
        esa = negs % 2;
    endtask

    task automatic check_out(input string tag, input int e1, input int e2,
                             input int eidx, input int esv, input int esa);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_min1"},  32'(min1),      32'(e1));
        chk({tag, "_min2"},  32'(min2),      32'(e2));
        chk({tag, "_idx"},   32'(min1_idx),  32'(eidx));
        chk({tag, "_sv"},    32'(sign_vec),  32'(esv));
        chk({tag, "_sa"},    32'(sign_all),  32'(esa));
    endtask

    // Offer one message, waiting (bounded) for in_ready; returns just after the accepting edge.
    task automatic send(input int v);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            chk("ready_timeout", 32'd0, 32'd1);
        end else begin
            in_valid = 1'b1;
            in_msg   = v[9:0];
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            xfer_cyc = cyc;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic release_result(input int delay);
        repeat (delay) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("rel_valid", 32'(out_valid), 32'd0);
        chk("rel_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic send_row(input int m[6], input int bub_after, input int bub_len);
        for (int i = 0; i < 6; i++) begin
            send(m[i]);
            if (i == bub_after) idle(bub_len);
        end
    endtask

    initial begin
        int m[6];
        int e1, e2, eidx, esv, esa;
        int t_a, t_b;
        n_chk     = 0;
        n_err     = 0;
        cyc       = 0;
        xfer_cyc  = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_msg    = '0;
        out_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_min1",  32'(min1), 32'd0);
        chk("rst_min2",  32'(min2), 32'd0);
        chk("rst_idx",   32'(min1_idx), 32'd0);
        chk("rst_sv",    32'(sign_vec), 32'd0);
        chk("rst_sa",    32'(sign_all), 32'd0);
        rst = 1'b1;

        // Ties and the most-negative code.
        m = '{5, -3, 7, -3, 100, -512};
        send_row(m, -1, 0);
        check_out("row_tie", 3, 3, 1, 6'b101010, 1);
        release_result(0);

        // All saturated.
        m = '{-512, -512, -512, -512, -512, -512};
        send_row(m, -1, 0);
        check_out("row_sat", 511, 511, 0, 6'b111111, 0);
        release_result(1);

        // Bubble after message 2 and exact latency.
        m = '{9, 8, 7, 6, 0, 1};
        for (int i = 0; i < 6; i++) begin
            send(m[i]);
            if (i == 2) idle(2);
            if (i == 4) chk("lat_pre", 32'(out_valid), 32'd0);
        end
        check_out("row_bub", 0, 1, 4, 6'b000000, 0);

        // Held result ignores traffic while out_ready is low.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_msg   = 10'($urandom);
            @(posedge clk);
            #1;
            check_out("stall", 0, 1, 4, 6'b000000, 0);
            chk("stall_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        release_result(0);
        m = '{-40, 33, 12, -12, 400, -7};
        send_row(m, -1, 0);
        model(m, e1, e2, eidx, esv, esa);
        check_out("after_stall", e1, e2, eidx, esv, esa);
        release_result(0);

        // Asynchronous reset mid-row.
        send(100);
        send(200);
        send(300);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_min1",  32'(min1), 32'd0);
        chk("arst_min2",  32'(min2), 32'd0);
        chk("arst_idx",   32'(min1_idx), 32'd0);
        chk("arst_sv",    32'(sign_vec), 32'd0);
        chk("arst_sa",    32'(sign_all), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        m = '{20, 30, 10, 40, 50, 60};
        send_row(m, -1, 0);
        check_out("post_rst", 10, 20, 2, 6'b000000, 0);
        release_result(0);

        // Back-to-back rows with out_ready held high.
        out_ready = 1'b1;
        m = '{-1, 2, -3, 4, -5, 6};
        send(m[0]);
        t_a = xfer_cyc;
        for (int i = 1; i < 6; i++) send(m[i]);
        check_out("b2b_a", 1, 2, 0, 6'b010101, 1);
        m = '{300, -299, 511, -511, 298, 297};
        send(m[0]);
        t_b = xfer_cyc;
        for (int i = 1; i < 6; i++) send(m[i]);
        model(m, e1, e2, eidx, esv, esa);
        check_out("b2b_b", e1, e2, eidx, esv, esa);
        chk("b2b_period", 32'(t_b - t_a), 32'd7);
        out_ready = 1'b0;
        release_result(0);

        // Randomized rows with bubbles and downstream back-pressure.
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 6; i++) begin
                case ($urandom_range(0, 3))
                    0:       m[i] = -512;
                    1:       m[i] = int'($urandom_range(0, 14)) - 7;
                    2:       m[i] = int'($urandom_range(0, 1023)) - 512;
                    default: m[i] = ($urandom_range(0, 1) == 1) ? 511 : -511;
                endcase
            end
            send_row(m, int'($urandom_range(0, 7)), int'($urandom_range(1, 3)));
            model(m, e1, e2, eidx, esv, esa);
            check_out("rand", e1, e2, eidx, esv, esa);
            release_result(int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=%0d expected=%0d", cyc, 0);
        $fatal(1);
    end

endmodule
